// File: rtl/axis_to_axi4_wr_m.sv
// Write DMA stage: accepts an AXI-Stream of data beats and writes them to
// memory as AXI4 INCR bursts, one burst outstanding at a time. Bursts are
// capped by BURST_LEN, by the beats still to send, and by the next 4KB
// boundary so that no burst ever crosses a 4KB page.
module axis_to_axi4_wr_m #(
    parameter int ID_W      = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // transfer control
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    beats,
    output logic                busy,
    output logic                done,
    output logic                err_resp,
    output logic                err_last,
    // stream slave
    input  logic                s_TVALID,
    output logic                s_TREADY,
    input  logic [DATA_W-1:0]   s_TDATA,
    input  logic [DATA_W/8-1:0] s_TKEEP,
    input  logic                s_TLAST,
    // AXI4 write address channel
    output logic [ID_W-1:0]     AWID,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic [3:0]          AWQOS,
    output logic [3:0]          AWREGION,
    // AXI4 write data channel
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    // AXI4 write response channel
    input  logic [ID_W-1:0]     BID,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [8:0]        burstLen_q, burstLen_d;
    logic [8:0]        beatCnt_q, beatCnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              errResp_q, errResp_d;
    logic              errLast_q, errLast_d;

    logic [12:0]       bytesToBoundary;
    logic [12:0]       beatsToBoundary;
    logic [31:0]       remainingExt;
    logic [31:0]       boundaryExt;
    logic [31:0]       blenExt;
    logic [8:0]        nextLen;
    logic              beatIsLast;
    logic              isLastBurst;
    logic              wBeat;
    logic              unusedBid;

    // Size of the next burst: smallest of the burst cap, beats left and beats to the 4KB page end
    always_comb begin
        bytesToBoundary = 13'h1000 - {1'b0, addr_q[11:0]};
        beatsToBoundary = bytesToBoundary >> SIZE;
        remainingExt    = 32'(remaining_q);
        boundaryExt     = 32'(beatsToBoundary);
        blenExt         = 32'(BURST_LEN);
        if (remainingExt < blenExt) begin
            blenExt = remainingExt;
        end
        if (boundaryExt < blenExt) begin
            blenExt = boundaryExt;
        end
        nextLen = 9'(blenExt);
    end

    assign beatIsLast  = (beatCnt_q == (burstLen_q - 9'd1));
    assign isLastBurst = (32'(remaining_q) == 32'(burstLen_q));
    assign wBeat       = (state_q == S_DATA) && s_TVALID && WREADY;

    // Next-state logic: burst sequencing, address/count bookkeeping and sticky error flags
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burstLen_d  = burstLen_q;
        beatCnt_d   = beatCnt_q;
        busy_d      = busy_q;
        errResp_d   = errResp_q;
        errLast_d   = errLast_q;
        done_d      = (state_q == S_DONE);
        if (done_q) begin
            busy_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    addr_d      = base_addr;
                    remaining_d = beats;
                    errResp_d   = 1'b0;
                    errLast_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (beats == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (AWREADY) begin
                    burstLen_d = nextLen;
                    beatCnt_d  = 9'd0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (wBeat) begin
                    beatCnt_d = beatCnt_q + 9'd1;
                    if (s_TLAST != (beatIsLast && isLastBurst)) begin
                        errLast_d = 1'b1;
                    end
                    if (beatIsLast) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (BVALID) begin
                    if (BRESP != 2'b00) begin
                        errResp_d = 1'b1;
                    end
                    addr_d      = addr_q + (ADDR_W'(burstLen_q) << SIZE);
                    remaining_d = remaining_q - CNT_W'(burstLen_q);
                    state_d     = isLastBurst ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial transfer
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            burstLen_q  <= '0;
            beatCnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            errResp_q   <= 1'b0;
            errLast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burstLen_q  <= burstLen_d;
            beatCnt_q   <= beatCnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            errResp_q   <= errResp_d;
            errLast_q   <= errLast_d;
        end
    end

    // AW channel: address and length are stable for the whole ADDR state
    assign AWVALID  = (state_q == S_ADDR);
    assign AWADDR   = addr_q;
    assign AWLEN    = 8'(nextLen - 9'd1);
    assign AWID     = '0;
    assign AWSIZE   = 3'(SIZE);
    assign AWBURST  = 2'b01;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'b0011;
    assign AWPROT   = 3'b000;
    assign AWQOS    = 4'h0;
    assign AWREGION = 4'h0;

    // W channel is a pass-through of the stream, opened only after AW has been accepted
    assign WVALID   = (state_q == S_DATA) && s_TVALID;
    assign s_TREADY = (state_q == S_DATA) && WREADY;
    assign WDATA    = s_TDATA;
    assign WSTRB    = s_TKEEP;
    assign WLAST    = (state_q == S_DATA) && beatIsLast;

    assign BREADY   = (state_q == S_RESP);

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_resp = errResp_q;
    assign err_last = errLast_q;

    assign unusedBid = ^BID;

endmodule
